// File: rtl/imem_loader_resp.sv
// Instruction memory with a byte-serial program loader.
// In RUN it serves IF-stage fetches with one cycle of latency. In LOAD it
// assembles little-endian words from a byte stream and writes them from word 0 up.
module imem_loader_resp #(
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   output logic [31:0] rsp_ins,
   output logic        rsp_err,
   output logic        stall,
   input  logic        ld_start,
   input  logic [7:0]  ld_len,
   input  logic        ld_byte_valid,
   input  logic [7:0]  ld_byte,
   output logic        ld_done
);

   typedef enum logic {RUN, LOAD} state_t;

   state_t          state;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   word_ptr;
   logic [AW-1:0]   last_idx;
   logic [AW-1:0]   ld_last;
   logic [1:0]      byte_cnt;
   logic [31:0]     asm_word;
   logic [31:0]     asm_next;
   logic            wr_en;
   logic            out_of_range;

   assign out_of_range = |req_addr[31:AW];
   assign wr_en        = (state == LOAD) && ld_byte_valid && (byte_cnt == 2'd3);

   // Index of the final word of a load; a zero or oversized length fills the whole memory.
   always_comb begin
      if (ld_len == 8'd0 || 32'(ld_len) > DEPTH)
         ld_last = AW'(DEPTH - 1);
      else
         ld_last = AW'(ld_len - 8'd1);
   end

   // Assembly register with the incoming byte dropped into its lane.
   always_comb begin
      asm_next = asm_word;
      case (byte_cnt)
         2'd0:    asm_next[7:0]   = ld_byte;
         2'd1:    asm_next[15:8]  = ld_byte;
         2'd2:    asm_next[23:16] = ld_byte;
         default: asm_next[31:24] = ld_byte;
      endcase
   end

   // Memory array is written only by the loader and never cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[word_ptr] <= asm_next;
   end

   // RUN/LOAD controller with registered fetch response, stall and done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         stall     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_ins   <= 32'd0;
         ld_done   <= 1'b0;
         word_ptr  <= '0;
         last_idx  <= '0;
         byte_cnt  <= 2'd0;
         asm_word  <= 32'd0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         ld_done   <= 1'b0;
         case (state)
            RUN: begin
               if (req_valid) begin
                  rsp_valid <= 1'b1;
                  if (out_of_range) begin
                     rsp_err <= 1'b1;
                     rsp_ins <= 32'd0;
                  end else begin
                     rsp_ins <= mem[req_addr[AW-1:0]];
                  end
               end
               if (ld_start) begin
                  last_idx <= ld_last;
                  word_ptr <= '0;
                  byte_cnt <= 2'd0;
                  asm_word <= 32'd0;
                  state    <= LOAD;
                  stall    <= 1'b1;
               end
            end
            LOAD: begin
               if (ld_byte_valid) begin
                  asm_word <= asm_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     word_ptr <= word_ptr + 1'b1;
                     if (word_ptr == last_idx) begin
                        state   <= RUN;
                        stall   <= 1'b0;
                        ld_done <= 1'b1;
                     end
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader_resp.sv
// Testbench for imem_loader_resp: directed loads and fetches, a byte-stream
// level reference model checked every cycle, plus hand-computed literal checks.
module tb_imem_loader_resp;

   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic        ld_start = 1'b0;
   logic [7:0]  ld_len = 8'd0;
   logic        ld_byte_valid = 1'b0;
   logic [7:0]  ld_byte = 8'd0;
   logic        rsp_valid;
   logic [31:0] rsp_ins;
   logic        rsp_err;
   logic        stall;
   logic        ld_done;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   imem_loader_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .rsp_valid(rsp_valid),
      .rsp_ins(rsp_ins),
      .rsp_err(rsp_err),
      .stall(stall),
      .ld_start(ld_start),
      .ld_len(ld_len),
      .ld_byte_valid(ld_byte_valid),
      .ld_byte(ld_byte),
      .ld_done(ld_done)
   );

   // Reference model: tracks whether a load is open, how many bytes it has
   // consumed, and which words the memory holds.
   logic [31:0] m_mem [DEPTH];
   bit          m_written [DEPTH];
   bit          m_loading = 1'b0;
   int          m_len = DEPTH;
   int          m_nbytes = 0;
   int          m_idx = 0;
   logic [7:0]  m_q[$];
   bit          e_valid = 1'b0;
   bit          e_err = 1'b0;
   bit          e_done = 1'b0;
   logic [31:0] e_ins = 32'd0;
   bit          e_ins_known = 1'b1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance the model on every clock edge, or clear it on reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_loading   = 1'b0;
         m_nbytes    = 0;
         m_q.delete();
         e_valid     = 1'b0;
         e_err       = 1'b0;
         e_done      = 1'b0;
         e_ins       = 32'd0;
         e_ins_known = 1'b1;
      end else begin
         e_valid = 1'b0;
         e_err   = 1'b0;
         e_done  = 1'b0;
         if (!m_loading) begin
            if (req_valid) begin
               e_valid = 1'b1;
               if ((req_addr >> AW) != 32'd0) begin
                  e_err       = 1'b1;
                  e_ins       = 32'd0;
                  e_ins_known = 1'b1;
               end else begin
                  e_ins       = m_mem[req_addr[AW-1:0]];
                  e_ins_known = m_written[req_addr[AW-1:0]];
               end
            end
            if (ld_start) begin
               m_loading = 1'b1;
               m_len     = (ld_len == 8'd0 || int'(ld_len) > DEPTH) ? DEPTH : int'(ld_len);
               m_nbytes  = 0;
               m_q.delete();
            end
         end else if (ld_byte_valid) begin
            m_q.push_back(ld_byte);
            m_nbytes++;
            if (m_q.size() == 4) begin
               m_idx = m_nbytes / 4 - 1;
               m_mem[m_idx]     = {m_q[3], m_q[2], m_q[1], m_q[0]};
               m_written[m_idx] = 1'b1;
               m_q.delete();
               if (m_idx == m_len - 1) begin
                  m_loading = 1'b0;
                  e_done    = 1'b1;
               end
            end
         end
      end
   end

   // Compare the DUT against the model in the middle of every cycle.
   always @(negedge clk) begin
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      checkOutput("rsp_err", 32'(rsp_err), 32'(e_err));
      checkOutput("stall", 32'(stall), 32'(m_loading));
      checkOutput("ld_done", 32'(ld_done), 32'(e_done));
      if (e_ins_known)
         checkOutput("rsp_ins", rsp_ins, e_ins);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs; on return the DUT has sampled them.
   task automatic applyStimulus(input bit rv, input logic [31:0] addr, input bit ls,
                                input logic [7:0] len, input bit bv, input logic [7:0] b);
      req_valid     = rv;
      req_addr      = addr;
      ld_start      = ls;
      ld_len        = len;
      ld_byte_valid = bv;
      ld_byte       = b;
      tick();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic fetch(input logic [31:0] addr);
      applyStimulus(1'b1, addr, 1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b1, b);
   endtask

   logic [7:0] prog2 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
   logic [7:0] prog1 [4] = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
   logic [7:0] progh [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0D, 8'hF0, 8'hFE, 8'hCA};

   initial begin
      #2 rst = 1'b1;
      tick();
      tick();
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("reset rsp_ins", rsp_ins, 32'd0);
      checkOutput("reset stall", 32'(stall), 32'd0);
      checkOutput("reset ld_done", 32'(ld_done), 32'd0);
      rst = 1'b0;
      tick();

      // Two-word load.
      applyStimulus(1'b0, 32'd0, 1'b1, 8'd2, 1'b0, 8'd0);
      checkOutput("stall after ld_start", 32'(stall), 32'd1);
      for (int i = 0; i < 8; i++) begin
         sendByte(prog2[i]);
         if (i < 7)
            checkOutput("stall during load", 32'(stall), 32'd1);
      end
      checkOutput("ld_done after 8th byte", 32'(ld_done), 32'd1);
      checkOutput("stall dropped with ld_done", 32'(stall), 32'd0);
      idle();
      checkOutput("ld_done single pulse", 32'(ld_done), 32'd0);

      // Back-to-back fetches.
      fetch(32'd0);
      checkOutput("fetch0 valid", 32'(rsp_valid), 32'd1);
      checkOutput("fetch0 ins", rsp_ins, 32'h12345678);
      fetch(32'd1);
      checkOutput("fetch1 ins", rsp_ins, 32'hDEADBEEF);
      fetch(32'd0);
      checkOutput("fetch0 again ins", rsp_ins, 32'h12345678);
      idle();
      checkOutput("no request valid", 32'(rsp_valid), 32'd0);
      checkOutput("rsp_ins held", rsp_ins, 32'h12345678);

      // Out-of-range fetch.
      fetch(32'h0000_0080);
      checkOutput("oor valid", 32'(rsp_valid), 32'd1);
      checkOutput("oor err", 32'(rsp_err), 32'd1);
      checkOutput("oor ins", rsp_ins, 32'd0);
      fetch(32'hFFFF_FFFF);
      checkOutput("oor high err", 32'(rsp_err), 32'd1);
      idle();
      checkOutput("err cleared", 32'(rsp_err), 32'd0);

      // Load bytes while in RUN have no effect.
      for (int i = 0; i < 3; i++)
         sendByte(8'h99);
      checkOutput("run bytes no stall", 32'(stall), 32'd0);

      // Reset in the middle of a load.
      applyStimulus(1'b0, 32'd0, 1'b1, 8'd2, 1'b0, 8'd0);
      for (int i = 0; i < 6; i++)
         sendByte((i < 4) ? prog2[i] : 8'(8'hA0 + i));
      req_valid = 1'b0;
      ld_byte_valid = 1'b0;
      #1 rst = 1'b1;
      #1 checkOutput("async reset stall", 32'(stall), 32'd0);
      #1 rst = 1'b0;
      tick();
      fetch(32'd0);
      checkOutput("mem0 kept over reset", rsp_ins, 32'h12345678);
      fetch(32'd1);
      checkOutput("mem1 kept over reset", rsp_ins, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'd0, 1'b1, 8'd1, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++)
         sendByte(prog1[i]);
      checkOutput("len1 ld_done", 32'(ld_done), 32'd1);
      fetch(32'd0);
      checkOutput("len1 word", rsp_ins, 32'h0BADF00D);

      // Requests held during LOAD and a stray ld_start.
      applyStimulus(1'b1, 32'd1, 1'b1, 8'd2, 1'b0, 8'd0);
      checkOutput("same-cycle fetch valid", 32'(rsp_valid), 32'd1);
      checkOutput("same-cycle fetch ins", rsp_ins, 32'hDEADBEEF);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'd0, (i == 1), 8'd1, 1'b1, progh[i]);
         checkOutput("fetch ignored in load", 32'(rsp_valid), 32'd0);
      end
      checkOutput("held-req ld_done", 32'(ld_done), 32'd1);
      fetch(32'd0);
      checkOutput("held-req word0", rsp_ins, 32'h11223344);
      fetch(32'd1);
      checkOutput("held-req word1", rsp_ins, 32'hCAFEF00D);

      // Full-depth load from ld_len=0, with gaps in the byte stream.
      applyStimulus(1'b0, 32'd0, 1'b1, 8'd0, 1'b0, 8'd0);
      for (int i = 0; i < 512; i++) begin
         if (i % 7 == 3)
            idle();
         sendByte(i[7:0]);
         if (i == 510)
            checkOutput("no early ld_done", 32'(ld_done), 32'd0);
      end
      checkOutput("full ld_done", 32'(ld_done), 32'd1);
      fetch(32'd127);
      checkOutput("word127", rsp_ins, 32'hFFFEFDFC);
      fetch(32'd0);
      checkOutput("word0 full", rsp_ins, 32'h03020100);
      for (int a = 0; a < DEPTH; a += 9)
         fetch(32'(a));
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
